// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler for two ALU lanes and one memory lane.
// Entries capture operands from completion broadcasts and issue oldest-first per FU class.
module rs_issue_scheduler #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ROB_W     = 6,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PAYLOAD_W = 48
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_alloc_valid,
    output logic                   o_alloc_ready,
    input  logic [ROB_W-1:0]       i_alloc_rob,
    input  logic                   i_alloc_mem,
    input  logic                   i_alloc_src0_rdy,
    input  logic                   i_alloc_src1_rdy,
    input  logic [ROB_W-1:0]       i_alloc_src0_tag,
    input  logic [ROB_W-1:0]       i_alloc_src1_tag,
    input  logic [DATA_W-1:0]      i_alloc_src0_val,
    input  logic [DATA_W-1:0]      i_alloc_src1_val,
    input  logic [PAYLOAD_W-1:0]   i_alloc_payload,
    input  logic [2:0]             i_wake_valid,
    input  logic [3*ROB_W-1:0]     i_wake_tag,
    input  logic [3*DATA_W-1:0]    i_wake_data,
    input  logic                   i_mem_busy,
    output logic [2:0]             o_issue_valid,
    output logic [3*ROB_W-1:0]     o_issue_rob,
    output logic [3*DATA_W-1:0]    o_issue_src0,
    output logic [3*DATA_W-1:0]    o_issue_src1,
    output logic [3*PAYLOAD_W-1:0] o_issue_payload,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = IdxW + 1;

    logic [DEPTH-1:0]     valid_q, valid_d, mem_q, mem_d;
    logic [DEPTH-1:0]     rdy0_q, rdy0_d, rdy1_q, rdy1_d;
    logic [ROB_W-1:0]     rob_q  [DEPTH];
    logic [ROB_W-1:0]     rob_d  [DEPTH];
    logic [ROB_W-1:0]     tag0_q [DEPTH];
    logic [ROB_W-1:0]     tag0_d [DEPTH];
    logic [ROB_W-1:0]     tag1_q [DEPTH];
    logic [ROB_W-1:0]     tag1_d [DEPTH];
    logic [DATA_W-1:0]    val0_q [DEPTH];
    logic [DATA_W-1:0]    val0_d [DEPTH];
    logic [DATA_W-1:0]    val1_q [DEPTH];
    logic [DATA_W-1:0]    val1_d [DEPTH];
    logic [PAYLOAD_W-1:0] pay_q  [DEPTH];
    logic [PAYLOAD_W-1:0] pay_d  [DEPTH];
    // older_q[j][i] set means entry j was allocated before entry i
    logic [DEPTH-1:0]     older_q [DEPTH];
    logic [DEPTH-1:0]     older_d [DEPTH];
    logic [CntW-1:0]      count_q, count_d;

    logic [2:0]             iv_q, iv_d;
    logic [3*ROB_W-1:0]     irob_q, irob_d;
    logic [3*DATA_W-1:0]    isrc0_q, isrc0_d, isrc1_q, isrc1_d;
    logic [3*PAYLOAD_W-1:0] ipay_q, ipay_d;

    logic [DEPTH-1:0] elig, alu_elig, mem_elig, issued;
    logic [DEPTH-1:0] sel [3];
    logic [IdxW-1:0]  free_idx;
    logic             alloc_fire;

    // Lowest matching lane wins; MSB of the result flags a hit.
    function automatic logic [DATA_W:0] wake_lookup(input logic [ROB_W-1:0]    tag,
                                                    input logic [2:0]          wv,
                                                    input logic [3*ROB_W-1:0]  wt,
                                                    input logic [3*DATA_W-1:0] wd);
        logic [DATA_W:0] r;
        r = '0;
        for (int k = 2; k >= 0; k--) begin
            if (wv[k] && wt[k*ROB_W +: ROB_W] == tag) r = {1'b1, wd[k*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    assign o_alloc_ready = (count_q < CntW'(DEPTH));
    assign o_count       = count_q;
    assign alloc_fire    = i_alloc_valid && o_alloc_ready && !i_flush;

    assign elig     = valid_q & rdy0_q & rdy1_q;
    assign alu_elig = elig & ~mem_q;
    assign mem_elig = elig & mem_q;
    assign issued   = sel[0] | sel[1] | sel[2];

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IdxW'(i);
        end
    end

    // Rank each eligible entry by how many older entries of its class are eligible.
    always_comb begin
        int unsigned n_alu;
        logic        any_mem;
        sel[0]  = '0;
        sel[1]  = '0;
        sel[2]  = '0;
        n_alu   = 0;
        any_mem = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            n_alu   = 0;
            any_mem = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (alu_elig[j] && older_q[j][i]) n_alu++;
                if (mem_elig[j] && older_q[j][i]) any_mem = 1'b1;
            end
            sel[0][i] = alu_elig[i] && (n_alu == 0);
            sel[1][i] = alu_elig[i] && (n_alu == 1);
            sel[2][i] = mem_elig[i] && !any_mem && !i_mem_busy;
        end
    end

    always_comb begin
        iv_d    = '0;
        irob_d  = '0;
        isrc0_d = '0;
        isrc1_d = '0;
        ipay_d  = '0;
        if (!i_flush) begin
            for (int k = 0; k < 3; k++) begin
                iv_d[k] = |sel[k];
                for (int i = 0; i < DEPTH; i++) begin
                    if (sel[k][i]) begin
                        irob_d[k*ROB_W +: ROB_W]         = rob_q[i];
                        isrc0_d[k*DATA_W +: DATA_W]      = val0_q[i];
                        isrc1_d[k*DATA_W +: DATA_W]      = val1_q[i];
                        ipay_d[k*PAYLOAD_W +: PAYLOAD_W] = pay_q[i];
                    end
                end
            end
        end
    end

    always_comb begin
        logic [DATA_W:0] hit0, hit1;
        valid_d = valid_q;
        mem_d   = mem_q;
        rdy0_d  = rdy0_q;
        rdy1_d  = rdy1_q;
        rob_d   = rob_q;
        tag0_d  = tag0_q;
        tag1_d  = tag1_q;
        val0_d  = val0_q;
        val1_d  = val1_q;
        pay_d   = pay_q;
        older_d = older_q;
        hit0    = '0;
        hit1    = '0;
        count_d = count_q + CntW'(alloc_fire) - CntW'(iv_d[0]) - CntW'(iv_d[1])
                  - CntW'(iv_d[2]);
        if (i_flush) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                hit0 = wake_lookup(tag0_q[i], i_wake_valid, i_wake_tag, i_wake_data);
                hit1 = wake_lookup(tag1_q[i], i_wake_valid, i_wake_tag, i_wake_data);
                if (valid_q[i] && !rdy0_q[i] && hit0[DATA_W]) begin
                    rdy0_d[i] = 1'b1;
                    val0_d[i] = hit0[DATA_W-1:0];
                end
                if (valid_q[i] && !rdy1_q[i] && hit1[DATA_W]) begin
                    rdy1_d[i] = 1'b1;
                    val1_d[i] = hit1[DATA_W-1:0];
                end
            end
            valid_d = valid_d & ~issued;
            if (alloc_fire) begin
                hit0 = wake_lookup(i_alloc_src0_tag, i_wake_valid, i_wake_tag, i_wake_data);
                hit1 = wake_lookup(i_alloc_src1_tag, i_wake_valid, i_wake_tag, i_wake_data);
                valid_d[free_idx] = 1'b1;
                mem_d[free_idx]   = i_alloc_mem;
                rob_d[free_idx]   = i_alloc_rob;
                tag0_d[free_idx]  = i_alloc_src0_tag;
                tag1_d[free_idx]  = i_alloc_src1_tag;
                pay_d[free_idx]   = i_alloc_payload;
                rdy0_d[free_idx]  = i_alloc_src0_rdy || hit0[DATA_W];
                rdy1_d[free_idx]  = i_alloc_src1_rdy || hit1[DATA_W];
                val0_d[free_idx]  = (!i_alloc_src0_rdy && hit0[DATA_W]) ? hit0[DATA_W-1:0]
                                                                         : i_alloc_src0_val;
                val1_d[free_idx]  = (!i_alloc_src1_rdy && hit1[DATA_W]) ? hit1[DATA_W-1:0]
                                                                         : i_alloc_src1_val;
                for (int j = 0; j < DEPTH; j++) older_d[j][free_idx] = 1'b1;
                older_d[free_idx] = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            mem_q   <= '0;
            rdy0_q  <= '0;
            rdy1_q  <= '0;
            count_q <= '0;
            iv_q    <= '0;
            irob_q  <= '0;
            isrc0_q <= '0;
            isrc1_q <= '0;
            ipay_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i]   <= '0;
                tag0_q[i]  <= '0;
                tag1_q[i]  <= '0;
                val0_q[i]  <= '0;
                val1_q[i]  <= '0;
                pay_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            mem_q   <= mem_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
            count_q <= count_d;
            iv_q    <= iv_d;
            irob_q  <= irob_d;
            isrc0_q <= isrc0_d;
            isrc1_q <= isrc1_d;
            ipay_q  <= ipay_d;
            rob_q   <= rob_d;
            tag0_q  <= tag0_d;
            tag1_q  <= tag1_d;
            val0_q  <= val0_d;
            val1_q  <= val1_d;
            pay_q   <= pay_d;
            older_q <= older_d;
        end
    end

    assign o_issue_valid   = iv_q;
    assign o_issue_rob     = irob_q;
    assign o_issue_src0    = isrc0_q;
    assign o_issue_src1    = isrc1_q;
    assign o_issue_payload = ipay_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed, table-driven bench for rs_issue_scheduler (DEPTH=8, ROB_W=6, DATA_W=32).
module tb_rs_issue_scheduler;

    logic          clk, rst_n, flush, alloc_valid, alloc_ready, alloc_mem;
    logic          s0_rdy, s1_rdy, mem_busy;
    logic [5:0]    alloc_rob, s0_tag, s1_tag;
    logic [31:0]   s0_val, s1_val;
    logic [47:0]   payload;
    logic [2:0]    wake_valid;
    logic [17:0]   wake_tag;
    logic [95:0]   wake_data;
    logic [2:0]    issue_valid;
    logic [17:0]   issue_rob;
    logic [95:0]   issue_src0, issue_src1;
    logic [143:0]  issue_payload;
    logic [3:0]    count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        alloc;
        logic        mem;
        logic [5:0]  rob;
        logic        r0;
        logic [5:0]  t0;
        logic [31:0] v0;
        logic        r1;
        logic [5:0]  t1;
        logic [31:0] v1;
        logic [2:0]  wv;
        logic [17:0] wt;
        logic [95:0] wd;
        logic        busy;
        logic        flush;
        logic [2:0]  e_v;
        logic [17:0] e_rob;
        logic [95:0] e_s0;
        logic [95:0] e_s1;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    rs_issue_scheduler #(
        .DEPTH(8), .ROB_W(6), .DATA_W(32), .PAYLOAD_W(48)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_flush          (flush),
        .i_alloc_valid    (alloc_valid),
        .o_alloc_ready    (alloc_ready),
        .i_alloc_rob      (alloc_rob),
        .i_alloc_mem      (alloc_mem),
        .i_alloc_src0_rdy (s0_rdy),
        .i_alloc_src1_rdy (s1_rdy),
        .i_alloc_src0_tag (s0_tag),
        .i_alloc_src1_tag (s1_tag),
        .i_alloc_src0_val (s0_val),
        .i_alloc_src1_val (s1_val),
        .i_alloc_payload  (payload),
        .i_wake_valid     (wake_valid),
        .i_wake_tag       (wake_tag),
        .i_wake_data      (wake_data),
        .i_mem_busy       (mem_busy),
        .o_issue_valid    (issue_valid),
        .o_issue_rob      (issue_rob),
        .o_issue_src0     (issue_src0),
        .o_issue_src1     (issue_src1),
        .o_issue_payload  (issue_payload),
        .o_count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] pay(input logic [5:0] r);
        return {24'hA5C3E1, 18'h0, r};
    endfunction

    function automatic vec_t nop();
        vec_t t;
        t = '0;
        return t;
    endfunction

    function automatic vec_t al(input logic m, input logic [5:0] rob,
                                input logic r0, input logic [5:0] t0, input logic [31:0] v0,
                                input logic r1, input logic [5:0] t1, input logic [31:0] v1);
        vec_t t;
        t = '0;
        t.alloc = 1'b1; t.mem = m; t.rob = rob;
        t.r0 = r0; t.t0 = t0; t.v0 = v0;
        t.r1 = r1; t.t1 = t1; t.v1 = v1;
        return t;
    endfunction

    function automatic vec_t wk(input vec_t t, input logic [2:0] wv, input logic [17:0] wt,
                                input logic [95:0] wd);
        vec_t r;
        r = t; r.wv = wv; r.wt = wt; r.wd = wd;
        return r;
    endfunction

    function automatic vec_t bz(input vec_t t);
        vec_t r;
        r = t; r.busy = 1'b1;
        return r;
    endfunction

    function automatic vec_t ex(input vec_t t, input logic [2:0] v, input logic [17:0] rob,
                                input logic [95:0] s0, input logic [95:0] s1,
                                input logic [3:0] c);
        vec_t r;
        r = t; r.e_v = v; r.e_rob = rob; r.e_s0 = s0; r.e_s1 = s1; r.e_cnt = c;
        return r;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_mem = 0; alloc_rob = '0; s0_rdy = 0; s1_rdy = 0;
        s0_tag = '0; s1_tag = '0; s0_val = '0; s1_val = '0; payload = '0;
        wake_valid = '0; wake_tag = '0; wake_data = '0; mem_busy = 0; flush = 0;
    endtask

    task automatic apply(input vec_t t, input string nm);
        logic [143:0] ep;
        alloc_valid = t.alloc; alloc_mem = t.mem; alloc_rob = t.rob;
        s0_rdy = t.r0; s0_tag = t.t0; s0_val = t.v0;
        s1_rdy = t.r1; s1_tag = t.t1; s1_val = t.v1;
        payload = pay(t.rob);
        wake_valid = t.wv; wake_tag = t.wt; wake_data = t.wd;
        mem_busy = t.busy; flush = t.flush;
        @(posedge clk);
        #1;
        ep = '0;
        for (int k = 0; k < 3; k++) begin
            if (t.e_v[k]) ep[k*48 +: 48] = pay(t.e_rob[k*6 +: 6]);
        end
        chk($sformatf("%s.valid", nm), 160'(issue_valid), 160'(t.e_v));
        chk($sformatf("%s.rob", nm), 160'(issue_rob), 160'(t.e_rob));
        chk($sformatf("%s.src0", nm), 160'(issue_src0), 160'(t.e_s0));
        chk($sformatf("%s.src1", nm), 160'(issue_src1), 160'(t.e_s1));
        chk($sformatf("%s.payload", nm), 160'(issue_payload), 160'(ep));
        chk($sformatf("%s.count", nm), 160'(count), 160'(t.e_cnt));
        chk($sformatf("%s.ready", nm), 160'(alloc_ready), 160'(t.e_cnt < 4'd8));
    endtask

    initial begin
        vec_t t;
        idle();
        rst_n = 1'b0;
        #12;
        chk("reset.count", 160'(count), 160'(0));
        chk("reset.ready", 160'(alloc_ready), 160'(1));
        chk("reset.valid", 160'(issue_valid), 160'(0));
        chk("reset.rob", 160'(issue_rob), 160'(0));
        chk("reset.payload", 160'(issue_payload), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic issue: ready ALU op issues one edge after allocation
        tbl.push_back(ex(al(0, 5, 1, 0, 32'h10, 1, 0, 32'h20), 0, '0, '0, '0, 1));
        tbl.push_back(ex(nop(), 3'b001, {12'd0, 6'd5}, {64'd0, 32'h10}, {64'd0, 32'h20}, 0));
        tbl.push_back(ex(nop(), 0, '0, '0, '0, 0));
        // Stored-entry wakeup on lane 1
        tbl.push_back(ex(al(0, 3, 1, 0, 32'h1, 0, 7, 0), 0, '0, '0, '0, 1));
        tbl.push_back(ex(nop(), 0, '0, '0, '0, 1));
        tbl.push_back(ex(wk(nop(), 3'b010, {6'd0, 6'd7, 6'd0}, {32'd0, 32'hDEADBEEF, 32'd0}),
                         0, '0, '0, '0, 1));
        tbl.push_back(ex(nop(), 3'b001, {12'd0, 6'd3}, {64'd0, 32'h1}, {64'd0, 32'hDEADBEEF}, 0));
        // Three waiters on tag 9: two ALU lanes in age order, then the third
        tbl.push_back(ex(al(0, 1, 0, 9, 32'hEE, 1, 0, 32'h11), 0, '0, '0, '0, 1));
        tbl.push_back(ex(al(0, 2, 0, 9, 32'h0, 1, 0, 32'h12), 0, '0, '0, '0, 2));
        tbl.push_back(ex(al(0, 3, 0, 9, 32'h0, 1, 0, 32'h13), 0, '0, '0, '0, 3));
        tbl.push_back(ex(wk(nop(), 3'b100, {6'd9, 12'd0}, {32'h99, 64'd0}), 0, '0, '0, '0, 3));
        tbl.push_back(ex(nop(), 3'b011, {6'd0, 6'd2, 6'd1}, {32'd0, 32'h99, 32'h99},
                         {32'd0, 32'h12, 32'h11}, 1));
        tbl.push_back(ex(nop(), 3'b001, {12'd0, 6'd3}, {64'd0, 32'h99}, {64'd0, 32'h13}, 0));
        tbl.push_back(ex(nop(), 0, '0, '0, '0, 0));
        // Allocation bypass from lane 0
        tbl.push_back(ex(wk(al(0, 6, 0, 4, 32'h0, 1, 0, 32'h66), 3'b001, {12'd0, 6'd4},
                            {64'd0, 32'h55}), 0, '0, '0, '0, 1));
        tbl.push_back(ex(nop(), 3'b001, {12'd0, 6'd6}, {64'd0, 32'h55}, {64'd0, 32'h66}, 0));
        // Two lanes hit the same tag: lane 1 beats lane 2
        tbl.push_back(ex(al(0, 7, 1, 0, 32'h7, 0, 8, 32'h0), 0, '0, '0, '0, 1));
        tbl.push_back(ex(wk(nop(), 3'b110, {6'd8, 6'd8, 6'd0}, {32'hC2, 32'hB1, 32'd0}),
                         0, '0, '0, '0, 1));
        tbl.push_back(ex(nop(), 3'b001, {12'd0, 6'd7}, {64'd0, 32'h7}, {64'd0, 32'hB1}, 0));
        // Age beats index: rob12 lands in slot 0 but is younger than rob11 in slot 1
        tbl.push_back(ex(al(0, 10, 1, 0, 32'hA0, 1, 0, 32'hA1), 0, '0, '0, '0, 1));
        tbl.push_back(ex(al(0, 11, 0, 20, 32'h0, 1, 0, 32'hB1), 3'b001, {12'd0, 6'd10},
                         {64'd0, 32'hA0}, {64'd0, 32'hA1}, 1));
        tbl.push_back(ex(al(0, 12, 0, 20, 32'h0, 1, 0, 32'hC1), 0, '0, '0, '0, 2));
        tbl.push_back(ex(wk(nop(), 3'b001, {12'd0, 6'd20}, {64'd0, 32'h20}), 0, '0, '0, '0, 2));
        tbl.push_back(ex(nop(), 3'b011, {6'd0, 6'd12, 6'd11}, {32'd0, 32'h20, 32'h20},
                         {32'd0, 32'hC1, 32'hB1}, 0));
        // Memory op held by busy for three cycles while an ALU op still issues
        tbl.push_back(ex(al(1, 4, 1, 0, 32'h40, 1, 0, 32'h41), 0, '0, '0, '0, 1));
        tbl.push_back(ex(bz(al(0, 8, 1, 0, 32'h80, 1, 0, 32'h81)), 0, '0, '0, '0, 2));
        tbl.push_back(ex(bz(nop()), 3'b001, {12'd0, 6'd8}, {64'd0, 32'h80}, {64'd0, 32'h81}, 1));
        tbl.push_back(ex(bz(nop()), 0, '0, '0, '0, 1));
        tbl.push_back(ex(nop(), 3'b100, {6'd4, 12'd0}, {32'h40, 64'd0}, {32'h41, 64'd0}, 0));
        tbl.push_back(ex(nop(), 0, '0, '0, '0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Fill, overflow attempt, then flush with concurrent alloc and wake
        for (int i = 0; i < 8; i++) begin
            apply(ex(al(0, 6'(32 + i), 0, 30, 32'h0, 1, 0, 32'h5), 0, '0, '0, '0, 4'(i + 1)),
                  $sformatf("fill%0d", i));
        end
        apply(ex(al(0, 40, 1, 0, 32'h4, 1, 0, 32'h4), 0, '0, '0, '0, 8), "full_drop");
        apply(ex(nop(), 0, '0, '0, '0, 8), "full_hold");
        t = ex(wk(al(0, 41, 1, 0, 32'h1, 1, 0, 32'h1), 3'b001, {12'd0, 6'd30}, {64'd0, 32'h3}),
               0, '0, '0, '0, 0);
        t.flush = 1'b1;
        apply(t, "flush");
        apply(ex(nop(), 0, '0, '0, '0, 0), "post_flush0");
        apply(ex(wk(nop(), 3'b001, {12'd0, 6'd30}, {64'd0, 32'h3}), 0, '0, '0, '0, 0),
              "post_flush_wake");
        apply(ex(nop(), 0, '0, '0, '0, 0), "post_flush1");
        apply(ex(al(0, 41, 1, 0, 32'h21, 1, 0, 32'h22), 0, '0, '0, '0, 1), "realloc");
        apply(ex(nop(), 3'b001, {12'd0, 6'd41}, {64'd0, 32'h21}, {64'd0, 32'h22}, 0),
              "realloc_issue");
        // Flush on the edge an entry would have issued
        apply(ex(al(0, 42, 1, 0, 32'h1, 1, 0, 32'h2), 0, '0, '0, '0, 1), "pre_flush");
        t = ex(nop(), 0, '0, '0, '0, 0);
        t.flush = 1'b1;
        apply(t, "flush_kill");
        apply(ex(nop(), 0, '0, '0, '0, 0), "flush_kill_after");

        // Asynchronous reset in the middle of a cycle drops a ready entry
        apply(ex(al(0, 43, 1, 0, 32'h9, 1, 0, 32'h9), 0, '0, '0, '0, 1), "pre_reset");
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset.count", 160'(count), 160'(0));
        chk("midreset.ready", 160'(alloc_ready), 160'(1));
        chk("midreset.valid", 160'(issue_valid), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;
        apply(ex(nop(), 0, '0, '0, '0, 0), "post_reset0");
        apply(ex(nop(), 0, '0, '0, '0, 0), "post_reset1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
